// File: rtl/input_register_pkg.sv
// Shared constants for the sticky input capture register.
// Names the two capture modes selected by EDGE_MODE.
package input_register_pkg;

  localparam int EDGE_LEVEL = 0;
  localparam int EDGE_RISE  = 1;

endpackage

// File: rtl/input_register_sync_chain.sv
// Generic N-flop synchronizer with synchronous reset.
// STAGES=0 degenerates to a plain wire.
module sync_chain #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o
);

  generate
    if (STAGES == 0) begin : g_pass
      assign data_o = data_i;
    end else begin : g_sync
      logic [WIDTH-1:0] sync_q [STAGES];

      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          for (int i = 0; i < STAGES; i++)
            sync_q[i] <= '0;
        end else begin
          sync_q[0] <= data_i;
          for (int i = 1; i < STAGES; i++)
            sync_q[i] <= sync_q[i-1];
        end
      end

      assign data_o = sync_q[STAGES-1];
    end
  endgenerate

endmodule

// File: rtl/input_register.sv
// Sticky capture of slow/async strobes into clk_i.
// Bits latch high on capture and hold until clr_i.
module input_register
  import input_register_pkg::*;
#(
  parameter int WIDTH       = 1,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_MODE   = EDGE_LEVEL
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             clr_i,
  output logic [WIDTH-1:0] data_o
);

  logic [WIDTH-1:0] s;
  logic [WIDTH-1:0] set;

  sync_chain #(
    .WIDTH  (WIDTH),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .data_i (data_i),
    .data_o (s)
  );

  generate
    if (EDGE_MODE == EDGE_RISE) begin : g_rise
      // s_prev is not touched by clr_i, so a held level never re-fires
      logic [WIDTH-1:0] s_prev;

      always_ff @(posedge clk_i) begin
        if (rst_i) s_prev <= '0;
        else       s_prev <= s;
      end

      assign set = s & ~s_prev;
    end else begin : g_level
      assign set = s;
    end
  endgenerate

  always_ff @(posedge clk_i) begin
    if (rst_i)      data_o <= '0;
    else if (clr_i) data_o <= '0;
    else            data_o <= data_o | set;
  end

endmodule

// File: tb/tb_input_register.sv
// Randomized bench for input_register against a
// sample-history model, three parameter sets at once.
module tb_input_register;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b0;
  logic       clr_i = 1'b0;
  logic [3:0] data_i = '0;
  logic [3:0] q_lvl;
  logic [3:0] q_rise;
  logic [1:0] q_s0;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  input_register #(
    .WIDTH(4), .SYNC_STAGES(2), .EDGE_MODE(0)
  ) u_lvl (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .data_i (data_i),
    .clr_i  (clr_i),
    .data_o (q_lvl)
  );

  input_register #(
    .WIDTH(4), .SYNC_STAGES(2), .EDGE_MODE(1)
  ) u_rise (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .data_i (data_i),
    .clr_i  (clr_i),
    .data_o (q_rise)
  );

  input_register #(
    .WIDTH(2), .SYNC_STAGES(0), .EDGE_MODE(1)
  ) u_s0 (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .data_i (data_i[1:0]),
    .clr_i  (clr_i),
    .data_o (q_s0)
  );

  // Model: history of every sampled data_i word,
  // indexed by edge number (edge 1 = first edge).
  logic [3:0] smp [0:4095];
  int         n_edge   = 0;
  int         last_rst = 0;
  logic [3:0] m_lvl    = '0;
  logic [3:0] m_rise   = '0;
  logic [3:0] m_s0     = '0;

  task automatic check(
    input string      tag,
    input logic [3:0] got,
    input logic [3:0] exp
  );
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s edge=%0d got=%b exp=%b",
               tag, n_edge, got, exp);
    end
  endtask

  // s seen at edge k with S sync stages: the word
  // sampled S edges earlier, unless reset wiped it.
  function automatic logic [3:0] s_at(
    input int k, input int st
  );
    int j;
    j = k - st;
    if (j < 1 || j <= last_rst) return 4'b0;
    return smp[j];
  endfunction

  task automatic step(
    input logic [3:0] d,
    input logic       c,
    input logic       r
  );
    logic [3:0] set_l, set_r, set_0;
    data_i = d;
    clr_i  = c;
    rst_i  = r;
    @(posedge clk_i);
    n_edge++;
    smp[n_edge] = d;
    set_l = s_at(n_edge, 2);
    set_r = s_at(n_edge, 2) & ~s_at(n_edge-1, 2);
    set_0 = s_at(n_edge, 0) & ~s_at(n_edge-1, 0);
    set_0 = set_0 & 4'b0011;
    if (r) begin
      m_lvl = '0; m_rise = '0; m_s0 = '0;
      last_rst = n_edge;
    end else if (c) begin
      m_lvl = '0; m_rise = '0; m_s0 = '0;
    end else begin
      m_lvl  = m_lvl  | set_l;
      m_rise = m_rise | set_r;
      m_s0   = m_s0   | set_0;
    end
    #1;
    check("lvl",  q_lvl,  m_lvl);
    check("rise", q_rise, m_rise);
    check("s0",   {2'b00, q_s0}, m_s0);
  endtask

  initial begin
    #1;
    check("pwrup_lvl",  q_lvl,  4'b0);
    check("pwrup_rise", q_rise, 4'b0);

    // reset held with inputs high
    for (int i = 0; i < 3; i++) begin
      step(4'hF, 1'b0, 1'b1);
      check("rst_hold", q_lvl, 4'h0);
    end
    step(4'hF, 1'b0, 1'b0);
    check("rel_e1", q_lvl, 4'h0);
    step(4'hF, 1'b0, 1'b0);
    check("rel_e2", q_lvl, 4'h0);
    step(4'hF, 1'b0, 1'b0);
    check("rel_e3", q_lvl, 4'hF);
    check("rel_e3r", q_rise, 4'hF);

    // drain, then single clear pulse
    for (int i = 0; i < 3; i++) step(4'h0, 1'b0, 1'b0);
    step(4'h0, 1'b1, 1'b0);
    check("clr", q_lvl, 4'h0);
    for (int i = 0; i < 5; i++) step(4'h0, 1'b0, 1'b0);
    check("clr_hold", q_lvl, 4'h0);

    // single-cycle pulse on bit 0
    step(4'h1, 1'b0, 1'b0);
    step(4'h0, 1'b0, 1'b0);
    check("pulse_e2", q_lvl, 4'h0);
    step(4'h0, 1'b0, 1'b0);
    check("pulse_e3", q_lvl, 4'h1);
    for (int i = 0; i < 22; i++) step(4'h0, 1'b0, 1'b0);
    check("pulse_sticky", q_lvl, 4'h1);

    // level held across a long clear
    for (int i = 0; i < 3; i++) step(4'h4, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step(4'h4, 1'b1, 1'b0);
      check("clr_lvl", q_lvl, 4'h0);
    end
    step(4'h4, 1'b0, 1'b0);
    check("lvl_recap", q_lvl, 4'h4);
    check("rise_lost", q_rise, 4'h0);

    // re-arm rising edge: drop then raise bit 2
    step(4'h0, 1'b0, 1'b0);
    step(4'h4, 1'b0, 1'b0);
    step(4'h4, 1'b0, 1'b0);
    step(4'h4, 1'b0, 1'b0);
    check("rise_rearm", q_rise, 4'h4);

    // no-sync instance: pulse bit1, then clr + bit0
    step(4'h0, 1'b1, 1'b0);
    step(4'h2, 1'b0, 1'b0);
    check("s0_b1", {2'b00, q_s0}, 4'h2);
    step(4'h1, 1'b1, 1'b0);
    check("s0_clr", {2'b00, q_s0}, 4'h0);
    step(4'h1, 1'b0, 1'b0);
    check("s0_lost", {2'b00, q_s0}, 4'h0);

    // randomized traffic
    for (int i = 0; i < 800; i++) begin
      logic [3:0] d;
      logic       c, r;
      d = 4'($urandom) & 4'($urandom);
      c = ($urandom_range(0, 9) == 0);
      r = ($urandom_range(0, 49) == 0);
      step(d, c, r);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
